// File: rtl/multi_timer_pkg.sv
// multi_timer_pkg
// Shared constants for the multi-channel timer: register offsets,
// CTRL bit positions, the channel reload state type and the
// rate-to-divider-tap table.
package multi_timer_pkg;

    // Register map: DIV sits at 0 and each channel owns three consecutive
    // slots starting at CH_BASE + CH_STRIDE*channel.
    localparam int REG_DIV   = 0;
    localparam int CH_BASE   = 1;
    localparam int CH_STRIDE = 3;
    localparam int OFF_COUNT = 0;
    localparam int OFF_MOD   = 1;
    localparam int OFF_CTRL  = 2;

    // CTRL layout; anything above CTRL_W reads back as zero.
    localparam int CTRL_W        = 4;
    localparam int CTRL_RATE_LSB = 0;
    localparam int CTRL_EN_BIT   = 2;
    localparam int CTRL_OS_BIT   = 3;

    // Lowest divider bits a channel may tap.
    localparam int TAP_BITS = 10;

    typedef enum logic {
        CH_RUN    = 1'b0,
        CH_RELOAD = 1'b1
    } ch_state_t;

    // Divider bit used as the count clock for each rate code.
    function automatic logic [3:0] rate_to_tap(input logic [1:0] rate);
        case (rate)
            2'b00:   return 4'd9;
            2'b01:   return 4'd3;
            2'b10:   return 4'd5;
            default: return 4'd7;
        endcase
    endfunction

endpackage

// File: rtl/timer_channel.sv
// timer_channel
// One timer channel: COUNT/MOD/CTRL registers, falling-edge detect on the
// selected divider tap, overflow reload window and the irq pulse.
// Ports:
//   clk1, nreset              clock, synchronous active-low reset
//   taps[9:0]                 low bits of the shared free-running divider
//   wr_count/wr_mod/wr_ctrl   decoded write strobes for this channel
//   wdata                     write data
//   count, mod, ctrl          register contents for read-back
//   irq                       one-cycle pulse after a completed reload
module timer_channel
    import multi_timer_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int RELOAD_DELAY = 4
) (
    input  logic                clk1,
    input  logic                nreset,
    input  logic [TAP_BITS-1:0] taps,
    input  logic                wr_count,
    input  logic                wr_mod,
    input  logic                wr_ctrl,
    input  logic [WIDTH-1:0]    wdata,
    output logic [WIDTH-1:0]    count,
    output logic [WIDTH-1:0]    mod,
    output logic [CTRL_W-1:0]   ctrl,
    output logic                irq
);

    ch_state_t          state_q, state_d;
    logic [3:0]         win_q, win_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   mod_q, mod_d;
    logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
    logic               tick_q, tick_d;
    logic               irq_q, irq_d;
    logic               tick_now;
    logic               inc;

    // Gated tap is registered every cycle so that a falling edge, whatever
    // its cause (divider wrap, DIV clear, enable drop, rate change), counts.
    // win_q counts down the remaining reload clocks; the edge where it
    // equals 1 is the reload edge.
    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        count_d  = count_q;
        mod_d    = mod_q;
        ctrl_d   = ctrl_q;
        irq_d    = 1'b0;
        tick_now = taps[rate_to_tap(ctrl_q[CTRL_RATE_LSB +: 2])] & ctrl_q[CTRL_EN_BIT];
        tick_d   = tick_now;
        inc      = tick_q & ~tick_now;

        if (wr_mod) begin
            mod_d = wdata;
        end
        if (wr_ctrl) begin
            ctrl_d = wdata[CTRL_W-1:0];
        end

        case (state_q)
            CH_RUN: begin
                if (wr_count) begin
                    count_d = wdata;
                end else if (inc) begin
                    if (count_q == '1) begin
                        count_d = '0;
                        state_d = CH_RELOAD;
                        win_d   = 4'(RELOAD_DELAY);
                    end else begin
                        count_d = count_q + WIDTH'(1);
                    end
                end
            end
            CH_RELOAD: begin
                // Increments are dropped while the window is open.
                if (win_q == 4'd1) begin
                    // A MOD write landing on the reload edge goes straight
                    // into COUNT; a COUNT write here loses to MOD.
                    count_d = wr_mod ? wdata : mod_q;
                    irq_d   = 1'b1;
                    state_d = CH_RUN;
                    win_d   = 4'd0;
                    if (ctrl_q[CTRL_OS_BIT]) begin
                        ctrl_d[CTRL_EN_BIT] = 1'b0;
                    end
                end else if (wr_count) begin
                    count_d = wdata;
                    state_d = CH_RUN;
                    win_d   = 4'd0;
                end else begin
                    win_d = win_q - 4'd1;
                end
            end
            default: begin
                state_d = CH_RUN;
                win_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk1) begin
        if (!nreset) begin
            state_q <= CH_RUN;
            win_q   <= 4'd0;
            count_q <= '0;
            mod_q   <= '0;
            ctrl_q  <= '0;
            tick_q  <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            count_q <= count_d;
            mod_q   <= mod_d;
            ctrl_q  <= ctrl_d;
            tick_q  <= tick_d;
            irq_q   <= irq_d;
        end
    end

    assign count = count_q;
    assign mod   = mod_q;
    assign ctrl  = ctrl_q;
    assign irq   = irq_q;

endmodule

// File: rtl/multi_timer.sv
// multi_timer
// Free-running divider shared by CHANNELS independent timer channels,
// with a small register file for configuration and read-back.
// Ports:
//   clk1    clock; every state change happens on its rising edge
//   nreset  synchronous active-low reset
//   addr    register select (0 = DIV, then COUNT/MOD/CTRL per channel)
//   wr      write strobe, one write per high cycle
//   wdata   write data
//   rdata   combinational read data for addr (all ones when unmapped)
//   irq     per-channel one-cycle overflow interrupt
module multi_timer
    import multi_timer_pkg::*;
#(
    parameter int CHANNELS     = 1,
    parameter int WIDTH        = 8,
    parameter int DIV_WIDTH    = 16,
    parameter int RELOAD_DELAY = 4,
    localparam int ADDR_W      = $clog2(1 + 3 * CHANNELS)
) (
    input  logic                clk1,
    input  logic                nreset,
    input  logic [ADDR_W-1:0]   addr,
    input  logic                wr,
    input  logic [WIDTH-1:0]    wdata,
    output logic [WIDTH-1:0]    rdata,
    output logic [CHANNELS-1:0] irq
);

    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0]     ch_count [CHANNELS];
    logic [WIDTH-1:0]     ch_mod   [CHANNELS];
    logic [CTRL_W-1:0]    ch_ctrl  [CHANNELS];

    // Divider always runs; any write to DIV restarts it from zero.
    always_comb begin
        div_d = div_q + DIV_WIDTH'(1);
        if (wr && (addr == ADDR_W'(REG_DIV))) begin
            div_d = '0;
        end
    end

    always_ff @(posedge clk1) begin
        if (!nreset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    // Read mux; DIV exposes the top WIDTH bits of the divider.
    always_comb begin
        rdata = '1;
        if (addr == ADDR_W'(REG_DIV)) begin
            rdata = div_q[DIV_WIDTH-1 -: WIDTH];
        end
        for (int c = 0; c < CHANNELS; c++) begin
            if (addr == ADDR_W'(CH_BASE + CH_STRIDE * c + OFF_COUNT)) begin
                rdata = ch_count[c];
            end
            if (addr == ADDR_W'(CH_BASE + CH_STRIDE * c + OFF_MOD)) begin
                rdata = ch_mod[c];
            end
            if (addr == ADDR_W'(CH_BASE + CH_STRIDE * c + OFF_CTRL)) begin
                rdata = WIDTH'(ch_ctrl[c]);
            end
        end
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        timer_channel #(
            .WIDTH        (WIDTH),
            .RELOAD_DELAY (RELOAD_DELAY)
        ) u_channel (
            .clk1     (clk1),
            .nreset   (nreset),
            .taps     (div_q[TAP_BITS-1:0]),
            .wr_count (wr && (addr == ADDR_W'(CH_BASE + CH_STRIDE * gi + OFF_COUNT))),
            .wr_mod   (wr && (addr == ADDR_W'(CH_BASE + CH_STRIDE * gi + OFF_MOD))),
            .wr_ctrl  (wr && (addr == ADDR_W'(CH_BASE + CH_STRIDE * gi + OFF_CTRL))),
            .wdata    (wdata),
            .count    (ch_count[gi]),
            .mod      (ch_mod[gi]),
            .ctrl     (ch_ctrl[gi]),
            .irq      (irq[gi])
        );
    end

endmodule

// File: doc/multi_timer.md
MULTI_TIMER -- requirements
Module: multi_timer

Interface
REQ-001 SHALL have parameter CHANNELS, default 1: number of independent timer channels (1..8).
REQ-002 SHALL have parameter WIDTH, default 8: counter, modulo and data bus width (8..16).
REQ-003 SHALL have parameter DIV_WIDTH, default 16: free-running divider width (10..24, >= WIDTH).
REQ-004 SHALL have parameter RELOAD_DELAY, default 4: clocks from overflow to modulo reload (1..8).
REQ-005 SHALL have port clk1  input  1: the only clock; all state changes on its rising edge.
REQ-006 SHALL have port nreset  input  1: reset, synchronous, active-low.
REQ-007 SHALL have port addr  input  ADDR_W = clog2(1+3*CHANNELS): register select.
REQ-008 SHALL have port wr  input  1: write strobe, one write per high cycle.
REQ-009 SHALL have port wdata  input  WIDTH: write data.
REQ-010 SHALL have port rdata  output  WIDTH: combinational read data for addr.
REQ-011 SHALL have port irq  output  CHANNELS: per-channel one-cycle overflow interrupt pulse.

Function
REQ-012 Register map SHALL be: 0 = DIV; 1+3c = COUNT[c]; 2+3c = MOD[c]; 3+3c = CTRL[c]; unmapped reads return all ones, unmapped writes are ignored.
REQ-013 The divider SHALL increment by 1 every clock and wrap at 2^DIV_WIDTH; DIV reads divider[DIV_WIDTH-1 -: WIDTH]; any DIV write clears the whole divider to 0.
REQ-014 CTRL[c] SHALL hold bits [1:0] rate, [2] enable, [3] one-shot; upper bits read 0; rate selects divider tap 00 -> bit 9, 01 -> bit 3, 10 -> bit 5, 11 -> bit 7.
REQ-015 COUNT[c] SHALL increment by 1 on each clock where the registered value of (selected tap AND enable) is 1 and its current value is 0 (falling-edge detect), so DIV write, enable clear or rate change can each cause one extra increment.
REQ-016 Increment of COUNT[c] at all ones SHALL wrap it to 0 and start a reload window of RELOAD_DELAY clocks; COUNT reads 0 during the window.
REQ-017 On the edge ending the window, COUNT[c] SHALL load the current MOD[c] and irq[c] SHALL be high for exactly the following clock cycle.
REQ-018 A COUNT[c] write inside the window (not on its final edge) SHALL store wdata and cancel both reload and irq.
REQ-019 A COUNT[c] write on the window's final edge SHALL be ignored; MOD[c] value wins.
REQ-020 A MOD[c] write on the window's final edge SHALL be loaded into both MOD[c] and COUNT[c].
REQ-021 A COUNT[c] write outside the window coinciding with an increment SHALL win; no increment applied.
REQ-022 With one-shot = 1, the reload edge SHALL also clear CTRL[c].enable.
REQ-023 Channels SHALL be fully independent; simultaneous overflows of several channels SHALL assert several irq bits in the same cycle.
REQ-024 Increments occurring during a channel's reload window SHALL be discarded.

Reset
REQ-025 On a clock with nreset low, divider, all COUNT, MOD, CTRL, edge registers and reload windows SHALL clear to 0 and irq SHALL be 0 the following cycle.
REQ-026 Reset asserted mid-window SHALL abort the reload with no irq.
REQ-027 Writes presented while nreset is low SHALL be ignored.

Structure
REQ-028 A shared package SHALL hold the register offset constants, CTRL bit positions and the rate-to-tap table.
REQ-029 Per-channel logic SHALL live in one sub-module timer_channel, instantiated CHANNELS times by generate; divider and address decode stay in multi_timer.

Verification
REQ-030 Defaults, MOD0=0xFE, CTRL0=0x05, COUNT0=0xFE -> COUNT0 steps every 16 clocks; overflow -> COUNT0=0 for 4 clocks, then 0xFE, irq[0] one cycle.
REQ-031 Overflow then COUNT0 write 0x33 two clocks later -> COUNT0=0x33, no irq, no reload.
REQ-032 Overflow, MOD0 write 0x80 on final window edge -> COUNT0=0x80 and irq pulse.
REQ-033 CTRL0=0x04, run until divider bit 9 = 1, write DIV -> COUNT0 increments once, DIV reads 0.
REQ-034 CHANNELS=2, CTRL0=0x0D one-shot, CTRL1=0x05 -> after channel 0 overflow, CTRL0 reads 0x09 and COUNT0 stops; channel 1 keeps counting.
REQ-035 nreset low for 1 clock during reload window -> all registers 0, irq stays 0.
